ofm_pre_se_ctrl: RTL and testbench

Sequencer for the pre-SE output-feature-map buffer BRAM (32-bit words, registered read, read address in byte units, internally shifted right by 2).
- Write phase: accepts a streamed OFM of cfg_num_words words from the conv/PW stage and writes them to consecutive BRAM rows.
- Read phase: replays the whole buffer cfg_rd_passes times to the SE path (pooling pass, then scale pass) over a valid/ready stream with full backpressure.
- Owns all BRAM control pins; the BRAM sees no other driver.

---
 rtl/ofm_pre_se_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ofm_pre_se_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ofm_pre_se_ctrl.sv
// Pre-SE OFM buffer sequencer: streams N words into the BRAM, then replays them
// cfg_rd_passes times through a 2-entry output FIFO. Perf counters under OFM_CTRL_PERF_EN.
module ofm_pre_se_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 10001,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_num_words,
  input  logic [3:0]            cfg_rd_passes,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_final,
  output logic                  bram_wr_rd_en,
  output logic [31:0]           bram_wr_addr,
  output logic [19:0]           bram_rd_addr,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out
`ifdef OFM_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_wr_stall,
  output logic [31:0]           perf_rd_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] L_DEPTH = CNT_WIDTH'(DEPTH);

  state_t                r_state;
  logic                  r_cfg_err;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [3:0]            r_passes;
  logic [CNT_WIDTH-1:0]  r_wr_idx;
  logic [CNT_WIDTH-1:0]  r_rd_idx;
  logic [3:0]            r_pass_idx;
  logic                  r_inflight;
  logic                  r_if_last;
  logic                  r_if_final;
  logic [19:0]           r_rd_addr;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic [1:0]            r_fifo_final;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_rd_pending;
  logic                  w_issue;
  logic                  w_rd_last;
  logic                  w_rd_final;
  logic                  w_rd_exit;
  logic [19:0]           w_issue_addr;

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign cfg_err       = r_cfg_err;
  assign in_ready      = (r_state == S_WR);
  assign bram_wr_rd_en = in_valid & in_ready;
  assign bram_wr_addr  = in_ready ? 32'(r_wr_idx) : 32'd0;
  assign bram_data_in  = in_ready ? in_data : '0;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_fifo_data[r_rptr] : '0;
  assign out_last  = out_valid & r_fifo_last[r_rptr];
  assign out_final = out_valid & r_fifo_final[r_rptr];
  assign w_pop     = out_valid & out_ready;

  // A pop in the same cycle frees a slot, which keeps the stream at one word per cycle.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_rd_pending = (r_pass_idx != r_passes);
  assign w_issue      = (r_state == S_RD) && w_rd_pending &&
                        ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
  assign w_rd_last    = (r_rd_idx == r_num - 1'b1);
  assign w_rd_final   = w_rd_last && (r_pass_idx == r_passes - 4'd1);
  assign w_issue_addr = 20'({r_rd_idx, 2'b00});
  assign bram_rd_addr = w_issue ? w_issue_addr : r_rd_addr;
  assign w_rd_exit    = !w_rd_pending && !r_inflight &&
                        ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cfg_err  <= 1'b0;
      r_num      <= '0;
      r_passes   <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_pass_idx <= '0;
      r_inflight <= 1'b0;
      r_if_last  <= 1'b0;
      r_if_final <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_last  <= w_rd_last;
        r_if_final <= w_rd_final;
        r_rd_addr  <= w_issue_addr;
      end
      case (r_state)
        S_IDLE: if (start) begin
          if (cfg_num_words > L_DEPTH) begin
            r_cfg_err <= 1'b1;
          end else begin
            r_cfg_err <= 1'b0;
            if (cfg_num_words == '0 || cfg_rd_passes == 4'd0) begin
              r_state <= S_DONE;
            end else begin
              r_num      <= cfg_num_words;
              r_passes   <= cfg_rd_passes;
              r_wr_idx   <= '0;
              r_rd_idx   <= '0;
              r_pass_idx <= '0;
              r_state    <= S_WR;
            end
          end
        end
        S_WR: if (in_valid) begin
          if (r_wr_idx == r_num - 1'b1) begin
            r_wr_idx <= '0;
            r_state  <= S_RD;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
        S_RD: begin
          if (w_issue) begin
            if (w_rd_last) begin
              r_rd_idx   <= '0;
              r_pass_idx <= r_pass_idx + 4'd1;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
          if (w_rd_exit) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture of the registered BRAM read, one cycle after issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_fifo_final   <= '0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= '0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wptr]  <= bram_data_out;
        r_fifo_last[r_wptr]  <= r_if_last;
        r_fifo_final[r_wptr] <= r_if_final;
        r_wptr               <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef OFM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_wr_stall <= '0;
      perf_rd_stall <= '0;
    end else if (r_state == S_IDLE && start && !(cfg_num_words > L_DEPTH)) begin
      perf_wr_stall <= '0;
      perf_rd_stall <= '0;
    end else begin
      if (r_state == S_WR && !in_valid && perf_wr_stall != '1)
        perf_wr_stall <= perf_wr_stall + 32'd1;
      if (r_state == S_RD && out_valid && !out_ready && perf_rd_stall != '1)
        perf_rd_stall <= perf_rd_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ofm_pre_se_ctrl.sv
// Directed bench for ofm_pre_se_ctrl: job table replayed through a behavioural BRAM,
// plus hand sequences for config errors, empty jobs and reset mid-read.
module tb_ofm_pre_se_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [13:0]   cfg_num_words;
  logic [3:0]    cfg_rd_passes;
  logic          busy, done, cfg_err;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last, out_final;
  logic [DW-1:0] out_data;
  logic          bram_wr_rd_en;
  logic [31:0]   bram_wr_addr;
  logic [19:0]   bram_rd_addr;
  logic [DW-1:0] bram_data_in, bram_data_out;
`ifdef OFM_CTRL_PERF_EN
  logic [31:0]   perf_wr_stall, perf_rd_stall;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ofm_pre_se_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_num_words(cfg_num_words), .cfg_rd_passes(cfg_rd_passes),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_final(out_final),
    .bram_wr_rd_en(bram_wr_rd_en), .bram_wr_addr(bram_wr_addr),
    .bram_rd_addr(bram_rd_addr), .bram_data_in(bram_data_in),
    .bram_data_out(bram_data_out)
`ifdef OFM_CTRL_PERF_EN
    , .perf_wr_stall(perf_wr_stall), .perf_rd_stall(perf_rd_stall)
`endif
  );

  // Behavioural BRAM with a registered read port.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (bram_wr_rd_en) mem[bram_wr_addr[5:0]] <= bram_data_in;
    bram_data_out <= mem[bram_rd_addr[7:2]];
  end

  typedef struct {
    int n; int passes; int stall_at; int stall_len; int base;
    bit glitch; int abort_at; bit chk_addr; int exp_pops;
  } job_t;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    int wr_i = 0, popped = 0, cyc = 0, last_pop = -10, stall_cnt = 0, issued = 0;
    int k, p;
    bit got_done = 0, rd_phase;
    logic [19:0] prev_addr;
    logic [19:0] addrs[$];
    logic [33:0] exp_w;
    @(negedge clk);
    cfg_num_words = 14'(j.n); cfg_rd_passes = 4'(j.passes);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk(busy === 1'b1, "busy_after_start", 64'(busy), 64'd1);
    prev_addr = bram_rd_addr;
    while (!got_done && cyc < 400) begin
      rd_phase = (wr_i == j.n);
      in_valid = (wr_i < j.n);
      in_data  = DW'(j.base * (wr_i + 1));
      start    = j.glitch && (wr_i == 2);
      if (start) cfg_num_words = 14'd0;
      if (j.stall_at >= 0 && popped == j.stall_at && stall_cnt < j.stall_len) begin
        out_ready = 1'b0; stall_cnt++;
      end else out_ready = 1'b1;
      #1;
      if (bram_wr_rd_en) begin
        chk(bram_wr_addr == 32'(wr_i), "wr_addr", 64'(bram_wr_addr), 64'(wr_i));
        chk(bram_data_in == DW'(j.base * (wr_i + 1)), "wr_data", 64'(bram_data_in), 64'(j.base * (wr_i + 1)));
        wr_i++;
      end
      if (rd_phase) begin
        if (bram_rd_addr != prev_addr) begin issued++; prev_addr = bram_rd_addr; end
        if (addrs.size() == 0 || addrs[$] != bram_rd_addr) addrs.push_back(bram_rd_addr);
      end
      if (out_valid && out_ready) begin
        k = popped % j.n; p = popped / j.n;
        exp_w = {(k == j.n - 1) && (p == j.passes - 1), k == j.n - 1, DW'(j.base * (k + 1))};
        chk({out_final, out_last, out_data} == exp_w, "pop_word", 64'({out_final, out_last, out_data}), 64'(exp_w));
        popped++; last_pop = cyc;
      end
      if (j.stall_at >= 0 && rd_phase)
        chk(issued - popped <= 2, "outstanding", 64'(issued - popped), 64'd2);
      if (done) begin
        got_done = 1;
        chk(cyc == last_pop + 1, "done_after_last_pop", 64'(cyc - last_pop), 64'd1);
        chk(popped == j.exp_pops, "pop_count", 64'(popped), 64'(j.exp_pops));
        chk(wr_i == j.n, "write_count", 64'(wr_i), 64'(j.n));
      end
      if (j.abort_at >= 0 && popped >= j.abort_at) begin
        start = 1'b0; in_valid = 1'b0;
        return;
      end
      if (!got_done) begin @(negedge clk); cyc++; end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (!got_done) chk(1'b0, "done_timeout", 64'(cyc), 64'd400);
    if (j.chk_addr) begin
      chk(addrs.size() == j.n, "rd_addr_count", 64'(addrs.size()), 64'(j.n));
      for (int i = 0; i < addrs.size() && i < j.n; i++)
        chk(addrs[i] == 20'(4 * i), "rd_addr_seq", 64'(addrs[i]), 64'(4 * i));
    end
  endtask

  job_t jobs[4];
  job_t jj;

  initial begin
    jobs[0] = '{4, 1, -1, 0, 'h11, 0, -1, 1, 4};
    jobs[1] = '{3, 2, -1, 0, 'hA0, 0, -1, 0, 6};
    jobs[2] = '{8, 1,  3, 5, 'h80, 0, -1, 0, 8};
    jobs[3] = '{5, 1, -1, 0, 'h50, 1, -1, 0, 5};

    reset_n = 1'b0; start = 1'b0; cfg_num_words = '0; cfg_rd_passes = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk({busy, done, cfg_err, in_ready, out_valid, out_last, out_final, bram_wr_rd_en} == 8'd0
        && bram_rd_addr == 20'd0 && bram_wr_addr == 32'd0, "reset_outputs",
        64'({busy, done, cfg_err, in_ready, out_valid, bram_wr_rd_en}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 4; t++) run_job(jobs[t]);

    // Oversized configuration is rejected and flagged until the next legal start.
    @(negedge clk);
    cfg_num_words = 14'd10002; cfg_rd_passes = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk(cfg_err === 1'b1, "cfg_err_set", 64'(cfg_err), 64'd1);
    chk(busy === 1'b0, "cfg_err_idle", 64'(busy), 64'd0);
    jj = '{2, 1, -1, 0, 'h30, 0, -1, 0, 2};
    run_job(jj);
    chk(cfg_err === 1'b0, "cfg_err_cleared", 64'(cfg_err), 64'd0);

    // Empty job: straight to DONE, no BRAM traffic.
    @(negedge clk);
    cfg_num_words = 14'd0; cfg_rd_passes = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk(busy && done && !bram_wr_rd_en, "empty_done", 64'({busy, done, bram_wr_rd_en}), 64'b110);
    @(negedge clk);
    #1;
    chk(!busy && !done, "empty_idle", 64'({busy, done}), 64'd0);

    // Reset in the middle of a read pass, then a fresh short job.
    jj = '{8, 3, -1, 0, 'h70, 0, 5, 0, 24};
    run_job(jj);
    reset_n = 1'b0; in_valid = 1'b0; start = 1'b0;
    #1;
    chk({busy, done, cfg_err, in_ready, out_valid, out_last, out_final, bram_wr_rd_en} == 8'd0
        && out_data == '0 && bram_rd_addr == 20'd0 && bram_wr_addr == 32'd0 && bram_data_in == '0,
        "reset_mid_rd", 64'({busy, done, out_valid, bram_rd_addr}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    jj = '{2, 1, -1, 0, 'hE0, 0, -1, 0, 2};
    run_job(jj);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
